// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Stage 0 forms bitwise generate/propagate; every prefix level is registered.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);
    localparam int W = WIDTH;
    localparam int L = $clog2(WIDTH);

    // Index 0 is the input register, index L feeds the output stage.
    logic [W-1:0]     r_g   [0:L];
    logic [W-1:0]     r_pg  [0:L];
    logic [W-1:0]     r_p   [0:L];
    logic [TAG_W-1:0] r_tag [0:L];
    logic [L:0]       r_c0;
    logic [L:0]       r_amsb;
    logic [L:0]       r_bmsb;
    logic [L:0]       r_valid;

    logic [W-1:0]     w_be;
    logic             w_c0;
    logic             w_stall;
    logic             w_adv;
    logic [W-1:0]     w_g_lvl  [1:L];
    logic [W-1:0]     w_pg_lvl [1:L];
    logic [W-1:0]     w_carry;

    assign w_be    = b ^ {W{sub}};
    assign w_c0    = cin ^ sub;
    assign w_stall = r_valid[L] & ~out_ready;
    assign w_adv   = ~w_stall;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int SPAN = 1 << (k - 1);
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= SPAN) begin : g_comb
                assign w_g_lvl[k][i]  = r_g[k-1][i] | (r_pg[k-1][i] & r_g[k-1][i-SPAN]);
                assign w_pg_lvl[k][i] = r_pg[k-1][i] & r_pg[k-1][i-SPAN];
            end else begin : g_pass
                assign w_g_lvl[k][i]  = r_g[k-1][i];
                assign w_pg_lvl[k][i] = r_pg[k-1][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_c0    <= '0;
            r_amsb  <= '0;
            r_bmsb  <= '0;
            for (int k = 0; k <= L; k++) begin
                r_g[k]   <= '0;
                r_pg[k]  <= '0;
                r_p[k]   <= '0;
                r_tag[k] <= '0;
            end
        end else begin
            // Flush overrides a stall and drops any input offered this cycle.
            if (flush) begin
                r_valid <= '0;
            end else if (w_adv) begin
                r_valid <= {r_valid[L-1:0], in_valid};
            end
            if (w_adv) begin
                r_g[0]    <= a & w_be;
                r_pg[0]   <= a ^ w_be;
                r_p[0]    <= a ^ w_be;
                r_tag[0]  <= tag;
                r_c0[0]   <= w_c0;
                r_amsb[0] <= a[W-1];
                r_bmsb[0] <= w_be[W-1];
                for (int k = 1; k <= L; k++) begin
                    r_g[k]    <= w_g_lvl[k];
                    r_pg[k]   <= w_pg_lvl[k];
                    r_p[k]    <= r_p[k-1];
                    r_tag[k]  <= r_tag[k-1];
                    r_c0[k]   <= r_c0[k-1];
                    r_amsb[k] <= r_amsb[k-1];
                    r_bmsb[k] <= r_bmsb[k-1];
                end
            end
        end
    end

    // Carry-in is folded in here: C[i] = G[i:0] | (P[i:0] & c0).
    assign w_carry   = r_g[L] | (r_pg[L] & {W{r_c0[L]}});
    assign sum       = r_p[L] ^ {w_carry[W-2:0], r_c0[L]};
    assign cout      = w_carry[W-1];
    assign ovf       = (r_amsb[L] == r_bmsb[L]) && (sum[W-1] != r_amsb[L]);
    assign zero      = r_valid[L] & ~|sum;
    assign out_valid = r_valid[L];
    assign in_ready  = ~w_stall;
    assign tag_out   = r_tag[L];

endmodule
